alu_share_sched: RTL
====================

# alu_share_sched

Round-robin scheduler that shares one registered 4-bit adder ALU among N_REQ requesters. Each requester offers a 4-bit operand pair with a valid/ready handshake. The block drives the shared ALU's operand nibbles and waits out the ALU's one-cycle register latency. It then returns the 5-bit sum, tagged with the requester index, on a single response channel with backpressure. It sits between the requesters and the ALU instance and is the only agent driving the ALU inputs.

## Interface
- N_REQ, default 4, number of requesters; legal range 2..8.
- ID_W, default 2, width of rsp_id; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  4*N_REQ  operand A; requester i uses bits [4i+3:4i].
- req_b  in  4*N_REQ  operand B; same packing as req_a.
- req_ready  out  N_REQ  per-requester accept strobe; at most one bit high at a time.
- alu_a  out  4  operand A to the shared ALU; registered.
- alu_b  out  4  operand B to the shared ALU; registered.
- alu_sum  in  5  ALU result. It is the ALU's registered output: the sum of the alu_a/alu_b present before a given edge appears after that edge.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns rsp_sum.
- rsp_sum  out  5  captured sum, {carry, sum[3:0]}.
- busy  out  1  high whenever state != IDLE.

## Operation
- State machine with four states: IDLE, EXEC, CAPT, RESP. Reset state is IDLE.
- IDLE
  - If any req_valid bit is high, pick a winner by round-robin. Search starts at index ptr and goes upward, wrapping from N_REQ-1 to 0.
  - req_ready[winner] is high combinationally in that same cycle. No other ready bit may be high.
  - At the edge: alu_a <= req_a[winner], alu_b <= req_b[winner], id register <= winner, ptr <= (winner+1) mod N_REQ, state <= EXEC.
  - If no req_valid bit is high, stay in IDLE with all req_ready low.
- EXEC: alu_a/alu_b held stable while the ALU registers the sum. Next state is CAPT.
- CAPT: alu_sum is valid. At the edge: rsp_sum <= alu_sum, rsp_id <= id, rsp_valid <= 1, state <= RESP.
- RESP
  - Hold rsp_valid, rsp_id and rsp_sum stable until rsp_valid && rsp_ready at an edge.
  - On that edge: rsp_valid <= 0, state <= IDLE.
  - No request is accepted in RESP, even when the handshake completes in that cycle.
- req_ready is low in every state except IDLE, and never depends on rsp_ready.
- Operands are captured at the accept edge. The requester may change or drop req_a, req_b and req_valid afterward without affecting the result.
- The block performs no arithmetic. rsp_sum is exactly the 5-bit alu_sum, so 0xF+0xF returns 5'h1E with no saturation.
- ptr wraps mod N_REQ. Requester indices >= N_REQ are never granted.
- Reset values: state IDLE, ptr 0, alu_a 0, alu_b 0, rsp_valid 0, rsp_id 0, rsp_sum 0, busy 0, req_ready all 0.
- Reset asserted mid-operation aborts the transaction.
  - All registers return to their reset values asynchronously.
  - A pending response is discarded.
  - The first grant after reset release starts the search from index 0.

## Timing
- Accept edge E0 is the IDLE cycle with req_ready[i]=1.
- alu_a/alu_b are valid after E0.
- The ALU registers the sum at E1.
- rsp_valid rises after E2, so accept-to-response latency is 2 cycles.
- If rsp_ready is held high, rsp_valid is high for exactly 1 cycle and the next accept can occur 4 cycles after the previous accept.
- Peak throughput is 1 operation per 4 cycles.
- Any requester holding req_valid high is granted within N_REQ transactions.

## Test plan
- Single request, N_REQ=4, rsp_ready=1:
  - Stimulus: req_valid=4'b0100, req_a[11:8]=3, req_b[11:8]=5.
  - Response: req_ready=4'b0100 for 1 cycle; alu_a=3, alu_b=5 after E0; rsp_valid for 1 cycle after E2 with rsp_id=2, rsp_sum=5'h08; busy high for 3 cycles.
- Carry case: requester 0 with a=0xF, b=0xF -> rsp_sum=5'h1E, rsp_id=0.
- Fairness: req_valid held at 4'b1111 -> grant order 0,1,2,3,0, with accepts exactly 4 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_valid, rsp_id and rsp_sum stay stable; req_ready stays 0 despite pending requests.
  - Raise rsp_ready: the handshake completes, the block returns to IDLE, and the next grant occurs 1 cycle later.
- Operand change after accept: change req_a from 2 to 9 the cycle after the accept (b=1) -> rsp_sum=5'h03 (2+1).
- Reset mid-EXEC: pulse rst_n low -> all outputs 0 immediately; no response emitted; next grant with req_valid=4'b1010 goes to requester 1.

Source files
------------

// File: rtl/alu_share_sched_if.sv
// Requester, shared-ALU and response signals of alu_share_sched.
// The scheduler uses the master modport; its environment uses slave.
interface alu_share_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [4:0]         alu_sum;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [4:0]         rsp_sum;
    logic               busy;

    modport master (
        input  req_valid, req_a, req_b, alu_sum, rsp_ready,
        output req_ready, alu_a, alu_b, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        output req_valid, req_a, req_b, alu_sum, rsp_ready,
        input  req_ready, alu_a, alu_b, rsp_valid, rsp_id, rsp_sum, busy
    );
endinterface

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one registered 4-bit adder among N_REQ
// requesters; returns the tagged 5-bit sum on a backpressured response port.
//
// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner
// EXEC  | operands held on the ALU while it registers the sum
// CAPT  | ALU sum valid; captured into the response register
// RESP  | response presented until rsp_ready
module alu_share_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [4:0]       r_rsp_sum;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic [3:0]       w_op_a;
    logic [3:0]       w_op_b;
    logic [N_REQ-1:0] w_req_ready;

    // Search upward from r_ptr, wrapping at N_REQ; first valid requester wins.
    always_comb begin : rr_pick
        int              v_idx;
        logic [ID_W-1:0] v_cand;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        v_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx  = (int'(r_ptr) + k) % N_REQ;
            v_cand = ID_W'(v_idx);
            if (!w_found && bus.req_valid[v_cand]) begin
                w_found = 1'b1;
                w_win   = v_cand;
            end
        end
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_op_a = bus.req_a[4*i +: 4];
                w_op_b = bus.req_b[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_req_ready = N_REQ'(1) << w_win;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = CAPT;
            CAPT: w_state_nxt = RESP;
            RESP: if (r_rsp_valid && bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_alu_a <= w_op_a;
                        r_alu_b <= w_op_b;
                        r_id    <= w_win;
                        r_ptr   <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
                    end
                end
                CAPT: begin
                    r_rsp_sum   <= bus.alu_sum;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.busy      = (r_state != IDLE);
endmodule
